// File: rtl/global_pkg.sv
// Shared memory-side types: MAU operation codes, arbiter state encoding and
// the default transaction timeout.
package global_pkg;

    typedef enum logic [1:0] {
        MEM_NONE,
        LOAD_DATA,
        STORE_DATA,
        FETCH_DATA
    } memory_operation_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_WAIT
    } arb_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Arbiter <-> MAU bus: request fields, handshake returns and the abort strobe.
interface mem_arbiter_if;
    import global_pkg::*;

    memory_operation_t memory_operation;
    logic              cyc;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ack;
    logic              data_valid;
    logic              done;
    logic              err;
    logic [31:0]       fetched_data;
    logic              abort;

    modport master (
        output memory_operation, cyc, funct3, addr, wdata, abort,
        input  ack, data_valid, done, err, fetched_data
    );

    modport slave (
        input  memory_operation, cyc, funct3, addr, wdata, abort,
        output ack, data_valid, done, err, fetched_data
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// 2-way round-robin chooser: a lone requester wins, a tie goes to the port
// that did not own the MAU last.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    assign pick = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the memory access unit: round-robin grant held
// until completion, with a saturating timeout that aborts a stuck transaction.
module mem_arbiter
    import global_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  memory_operation_t m0_memory_operation,
    input  logic              m0_cyc,
    input  logic [2:0]        m0_funct3,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_data_valid,
    output logic              m0_done,
    output logic              m0_err,

    input  memory_operation_t m1_memory_operation,
    input  logic              m1_cyc,
    input  logic [2:0]        m1_funct3,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_data_valid,
    output logic              m1_done,
    output logic              m1_err,

    output logic [31:0]       rdata,
    mem_arbiter_if.master     mau,

    output logic              grant,
    output logic              busy
);

    arb_state_t        state;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    memory_operation_t op_q;
    logic              pick;

    rr_pick u_pick (
        .req  ({m1_cyc, m0_cyc}),
        .last (last_grant),
        .pick (pick)
    );

    memory_operation_t sel_op;
    logic              sel_cyc;
    logic [2:0]        sel_funct3;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;

    always_comb begin
        sel_op     = grant ? m1_memory_operation : m0_memory_operation;
        sel_cyc    = grant ? m1_cyc              : m0_cyc;
        sel_funct3 = grant ? m1_funct3           : m0_funct3;
        sel_addr   = grant ? m1_addr             : m0_addr;
        sel_wdata  = grant ? m1_wdata            : m0_wdata;
    end

    logic in_grant, in_wait, complete, withdraw, timeout;

    assign in_grant = (state == ARB_GRANT);
    assign in_wait  = (state == ARB_WAIT);
    assign busy     = in_grant | in_wait;

    // The operation is latched at ack so completion decoding does not depend
    // on the requester holding its inputs steady through WAIT.
    assign complete = in_wait & (mau.err |
                      ((op_q == STORE_DATA) & mau.done) |
                      (((op_q == LOAD_DATA) | (op_q == FETCH_DATA)) & mau.data_valid));
    assign withdraw = in_grant & ~sel_cyc;
    assign timeout  = busy & (cnt == CNT_W'(TIMEOUT)) & ~complete & ~withdraw;

    always_comb begin
        mau.cyc              = in_grant & sel_cyc;
        mau.memory_operation = in_grant ? sel_op : MEM_NONE;
        mau.funct3           = in_grant ? sel_funct3 : 3'd0;
        mau.addr             = in_grant ? sel_addr : 32'd0;
        mau.wdata            = in_grant ? sel_wdata : 32'd0;
        mau.abort            = timeout;
    end

    logic rt_ack, rt_dv, rt_done, rt_err;

    assign rt_ack  = in_grant & mau.ack;
    assign rt_dv   = in_wait & mau.data_valid;
    assign rt_done = in_wait & mau.done;
    assign rt_err  = (in_wait & mau.err) | timeout;

    assign m0_ack        = rt_ack  & ~grant;
    assign m0_data_valid = rt_dv   & ~grant;
    assign m0_done       = rt_done & ~grant;
    assign m0_err        = rt_err  & ~grant;
    assign m1_ack        = rt_ack  & grant;
    assign m1_data_valid = rt_dv   & grant;
    assign m1_done       = rt_done & grant;
    assign m1_err        = rt_err  & grant;
    assign rdata         = mau.fetched_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            op_q       <= MEM_NONE;
        end else begin
            if (busy && cnt != '1)
                cnt <= cnt + 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (m0_cyc | m1_cyc) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (withdraw) begin
                        state <= ARB_IDLE;
                    end else if (timeout) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end else if (mau.ack) begin
                        op_q  <= sel_op;
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (complete | timeout) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory access unit (MAU) between two requesters: port 0 is the control unit (fetch/load/store) and port 1 is a secondary master (debug/DMA loader). It speaks the existing cyc/ack/data_valid/done/err handshake on both sides and grants one requester at a time. A grant holds until that requester's transaction completes. The block sits between the requesters and the MAU, and adds round-robin fairness and a transaction timeout.

Parameters:
TIMEOUT, 255, cycles a granted transaction may stay outstanding before it is aborted with err.
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-low.
m0_memory_operation, m1_memory_operation  input  memory_operation_t  requested operation per port.
m0_cyc, m1_cyc  input  1  request strobe per port.
m0_funct3, m1_funct3  input  3  access size/sign per port.
m0_addr, m1_addr  input  32  address per port.
m0_wdata, m1_wdata  input  32  store data per port.
m0_ack, m1_ack  output  1  ack routed to the granted port only.
m0_data_valid, m1_data_valid  output  1  data_valid routed to the granted port only.
m0_done, m1_done  output  1  done routed to the granted port only.
m0_err, m1_err  output  1  MAU err or timeout err routed to the granted port only.
rdata  output  32  MAU read data, broadcast to both ports.
memory_operation  output  memory_operation_t  to MAU; MEM_NONE when idle.
cyc  output  1  to MAU.
funct3, addr, wdata  output  3/32/32  to MAU, muxed by grant.
ack, data_valid, done, err  input  1 each  from MAU.
fetched_data  input  32  MAU read data.
abort  output  1  one-cycle pulse telling the MAU to drop its transaction on timeout.
grant  output  1  index of the port currently owning the MAU.
busy  output  1  high in GRANT and WAIT states.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, last_grant=1, counter=0.
  - All outputs 0; memory_operation=MEM_NONE.
  - Reset asserted mid-transaction discards it; no err is issued.
- States: IDLE, GRANT (waiting for ack), WAIT (waiting for completion).
- IDLE:
  - If exactly one mX_cyc is high, the next posedge latches grant=X and enters GRANT.
  - If both are high, grant = ~last_grant (round-robin); port 0 wins the first contention after reset.
  - Latency from request to MAU cyc is one cycle.
- GRANT:
  - cyc, memory_operation, funct3, addr and wdata are combinationally muxed from the granted port.
  - ack is passed combinationally to the granted port.
  - ack=1 -> WAIT, and cyc drops to the MAU.
  - Granted mX_cyc dropped before ack -> IDLE (withdrawal, no error).
- WAIT:
  - Completion is data_valid for FETCH_DATA/LOAD_DATA, done for STORE_DATA, or err for any operation.
  - The completion signal is passed combinationally to the granted port.
  - The next posedge sets last_grant=grant and returns to IDLE.
- Downstream cyc is 0 in IDLE and WAIT; the non-granted port sees ack, data_valid, done and err all 0.
- Timeout counter:
  - Clears on entry to GRANT and increments each cycle in GRANT or WAIT.
  - When counter==TIMEOUT: one-cycle pulse on abort and on the granted mX_err, then IDLE with last_grant updated.
  - Completion and timeout in the same cycle: completion wins; no abort, no err.
- A new request is never granted in the same cycle a completion occurs; at least one IDLE cycle separates transactions.
- The counter saturates and never wraps.

Decomposition:
- memory_operation_t is already in global_pkg.
- Add to global_pkg: arb_state_t {ARB_IDLE, ARB_GRANT, ARB_WAIT} and the MEM_TIMEOUT_DEFAULT constant.
- One sub-module, rr_pick: a 2-way round-robin chooser (inputs req[1:0] and last; output pick). Everything else stays flat.

Test Plan:
1. rst low, then high; m0_cyc=1 LOAD_DATA addr=0x100 -> cyc=1 and addr=0x100 the next cycle; ack routed to m0; MAU data_valid with fetched_data=0xDEADBEEF -> m0_data_valid=1 and rdata=0xDEADBEEF; m1 outputs stay 0.
2. m0_cyc and m1_cyc both high from reset -> grant=0 first; after completion grant=1; with both still requesting, grant alternates 0,1,0.
3. m1 STORE_DATA addr=0x200 wdata=0x12345678 -> wdata forwarded; done after ack -> m1_done=1 and state returns to IDLE; data_valid alone does not complete the store.
4. Granted transaction with ack but no completion -> after TIMEOUT=255 cycles, abort=1 and m0_err=1 for exactly one cycle, then IDLE; MAU done in the same cycle as the timeout instead -> no abort.
5. m0 raises cyc, then drops it before ack -> back to IDLE, no err; m1's pending request is granted next.
6. rst asserted during WAIT -> cyc=0, busy=0 and grant=0 immediately (asynchronous); no err pulse after release.
